// File: rtl/maxpool2x2_axis_if.sv
// AXI-Stream bundle shared by the pooling stage's input and output ports.
//   tvalid/tready : beat handshake
//   tdata         : payload (pixel in the low bits)
//   tstrb         : byte strobes
//   tlast         : last pixel of a line
//   tuser         : first pixel of a frame
// The master modport drives the payload; the slave modport drives tready.
interface maxpool2x2_axis_if #(
   parameter int C_AXIS_TDATA_WIDTH = 32
);
   logic                              tvalid;
   logic                              tready;
   logic [C_AXIS_TDATA_WIDTH-1:0]     tdata;
   logic [C_AXIS_TDATA_WIDTH/8-1:0]   tstrb;
   logic                              tlast;
   logic                              tuser;

   modport master (output tvalid, tdata, tstrb, tlast, tuser, input tready);
   modport slave  (input tvalid, tdata, tstrb, tlast, tuser, output tready);
endinterface

// File: rtl/maxpool2x2_axis.sv
// 2x2 / stride-2 max pooling of a signed pixel stream with optional ReLU.
// Ports:
//   clk          : single clock
//   reset        : synchronous, active-high
//   s00_axis     : input stream (one pixel per beat, tuser = frame start,
//                  tlast = end of line, tstrb and upper tdata bits ignored)
//   m00_axis     : pooled output stream (tuser on first output of a frame,
//                  tlast on last output of a pooled line, tstrb all ones)
//   overflow_err : sticky flag, set when a line exceeds MAX_LINE_WIDTH
module maxpool2x2_axis #(
   parameter int DATA_WIDTH         = 16,
   parameter int C_AXIS_TDATA_WIDTH = 32,
   parameter int MAX_LINE_WIDTH     = 1024,
   parameter int RELU_EN            = 1
) (
   input  logic              clk,
   input  logic              reset,
   maxpool2x2_axis_if.slave  s00_axis,
   maxpool2x2_axis_if.master m00_axis,
   output logic              overflow_err
);

   localparam int COL_W = $clog2(MAX_LINE_WIDTH) + 1;
   localparam int PAIRS = MAX_LINE_WIDTH / 2;
   localparam int K_W   = $clog2(PAIRS);
   localparam logic [COL_W-1:0] MAX_COL = COL_W'(MAX_LINE_WIDTH);

   typedef enum logic {ROW_EVEN, ROW_ODD} row_t;

   function automatic logic signed [DATA_WIDTH-1:0] relu(
      input logic signed [DATA_WIDTH-1:0] a);
      if (RELU_EN != 0 && a < 0) return '0;
      return a;
   endfunction

   function automatic logic signed [DATA_WIDTH-1:0] smax(
      input logic signed [DATA_WIDTH-1:0] a,
      input logic signed [DATA_WIDTH-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // control state
   logic [COL_W-1:0] col;
   row_t             row;
   logic             first_out;
   logic             pend_vld;

   // datapath state
   logic signed [DATA_WIDTH-1:0] pair_reg;
   logic signed [DATA_WIDTH-1:0] pend_data;
   logic signed [DATA_WIDTH-1:0] line_buf [PAIRS];

   // output register
   logic                          out_valid;
   logic [C_AXIS_TDATA_WIDTH-1:0] out_data;
   logic                          out_last;
   logic                          out_user;

   // per-beat decode; a tuser beat restarts the frame before being processed
   logic                         accept;
   logic [COL_W-1:0]             col_eff;
   row_t                         row_eff;
   logic                         pend_eff;
   logic                         first_eff;
   logic                         in_range;
   logic                         is_odd;
   logic [K_W-1:0]               k;
   logic signed [DATA_WIDTH-1:0] px;
   logic signed [DATA_WIDTH-1:0] v;
   logic signed [DATA_WIDTH-1:0] pair_max;
   logic signed [DATA_WIDTH-1:0] pool_max;
   logic                         unused_bits;

   assign accept    = s00_axis.tvalid && s00_axis.tready;
   assign col_eff   = s00_axis.tuser ? '0 : col;
   assign row_eff   = s00_axis.tuser ? ROW_EVEN : row;
   assign pend_eff  = s00_axis.tuser ? 1'b0 : pend_vld;
   assign first_eff = s00_axis.tuser ? 1'b1 : first_out;
   assign in_range  = (col_eff < MAX_COL);
   assign is_odd    = col_eff[0];
   assign k         = col_eff[K_W:1];
   assign px        = s00_axis.tdata[DATA_WIDTH-1:0];
   assign v         = relu(px);
   assign pair_max  = smax(pair_reg, v);
   assign pool_max  = smax(line_buf[k], pair_max);

   assign unused_bits = ^{s00_axis.tstrb, s00_axis.tdata};

   assign s00_axis.tready = !out_valid || m00_axis.tready;
   assign m00_axis.tvalid = out_valid;
   assign m00_axis.tdata  = out_data;
   assign m00_axis.tlast  = out_last;
   assign m00_axis.tuser  = out_user;
   assign m00_axis.tstrb  = '1;

   // Control and output register. A finished ODD-row result is parked in
   // pend_data and only emitted when the next pair starts or tlast arrives,
   // so the last complete pair of a line always carries tlast, even when an
   // odd trailing pixel follows it.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_last     <= 1'b0;
         out_user     <= 1'b0;
         overflow_err <= 1'b0;
         col          <= '0;
         row          <= ROW_EVEN;
         first_out    <= 1'b1;
         pend_vld     <= 1'b0;
      end else begin
         if (out_valid && m00_axis.tready) out_valid <= 1'b0;

         if (accept) begin
            first_out <= first_eff;
            pend_vld  <= pend_eff;

            if (!in_range) overflow_err <= 1'b1;

            if (in_range && is_odd && row_eff == ROW_ODD) begin
               if (s00_axis.tlast) begin
                  out_valid <= 1'b1;
                  out_data  <= C_AXIS_TDATA_WIDTH'($unsigned(pool_max));
                  out_last  <= 1'b1;
                  out_user  <= first_eff;
                  first_out <= 1'b0;
               end else begin
                  pend_vld  <= 1'b1;
               end
            end else if (pend_eff && ((in_range && !is_odd) || s00_axis.tlast)) begin
               out_valid <= 1'b1;
               out_data  <= C_AXIS_TDATA_WIDTH'($unsigned(pend_data));
               out_last  <= s00_axis.tlast;
               out_user  <= first_eff;
               first_out <= 1'b0;
               pend_vld  <= 1'b0;
            end

            if (s00_axis.tlast) begin
               col      <= '0;
               row      <= (row_eff == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
               pend_vld <= 1'b0;
            end else begin
               col <= in_range ? col_eff + COL_W'(1) : col_eff;
               row <= row_eff;
            end
         end
      end
   end

   // Pixel datapath: pair register, line buffer and parked result.
   always_ff @(posedge clk) begin
      if (accept && in_range) begin
         if (!is_odd) begin
            pair_reg <= v;
         end else if (row_eff == ROW_EVEN) begin
            line_buf[k] <= pair_max;
         end else if (!s00_axis.tlast) begin
            pend_data <= pool_max;
         end
      end
   end

endmodule

// File: tb/tb_maxpool2x2_axis.sv
module tb_maxpool2x2_axis;

   typedef struct {
      logic signed [15:0] px;
      bit                 last;
      bit                 user;
      bit                 out;
      logic signed [15:0] exp_relu;
      logic signed [15:0] exp_raw;
      bit                 exp_last;
      bit                 exp_user;
   } vec_t;

   typedef struct {
      logic [15:0] relu;
      logic [15:0] raw;
      bit          last;
      bit          user;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_last = 1'b0;
   logic        in_user = 1'b0;
   logic        out_ready = 1'b1;
   logic        ovf_relu, ovf_raw;
   int          ready_mode = 0;
   int          errors = 0;
   int          checks = 0;
   exp_t        sb[$];
   vec_t        frame_a[16];
   vec_t        frame_b[10];

   always #5 clk = ~clk;

   maxpool2x2_axis_if #(.C_AXIS_TDATA_WIDTH(32)) s_relu ();
   maxpool2x2_axis_if #(.C_AXIS_TDATA_WIDTH(32)) m_relu ();
   maxpool2x2_axis_if #(.C_AXIS_TDATA_WIDTH(32)) s_raw ();
   maxpool2x2_axis_if #(.C_AXIS_TDATA_WIDTH(32)) m_raw ();

   assign s_relu.tvalid = in_valid;
   assign s_relu.tdata  = in_data;
   assign s_relu.tstrb  = '1;
   assign s_relu.tlast  = in_last;
   assign s_relu.tuser  = in_user;
   assign m_relu.tready = out_ready;
   assign s_raw.tvalid  = in_valid;
   assign s_raw.tdata   = in_data;
   assign s_raw.tstrb   = '1;
   assign s_raw.tlast   = in_last;
   assign s_raw.tuser   = in_user;
   assign m_raw.tready  = out_ready;

   maxpool2x2_axis #(.DATA_WIDTH(16), .C_AXIS_TDATA_WIDTH(32),
                     .MAX_LINE_WIDTH(1024), .RELU_EN(1)) u_relu (
      .clk(clk), .reset(reset), .s00_axis(s_relu.slave),
      .m00_axis(m_relu.master), .overflow_err(ovf_relu));

   maxpool2x2_axis #(.DATA_WIDTH(16), .C_AXIS_TDATA_WIDTH(32),
                     .MAX_LINE_WIDTH(1024), .RELU_EN(0)) u_raw (
      .clk(clk), .reset(reset), .s00_axis(s_raw.slave),
      .m00_axis(m_raw.master), .overflow_err(ovf_raw));

   function automatic vec_t mk(input logic signed [15:0] px, input bit last,
                               input bit user, input bit out,
                               input logic signed [15:0] er,
                               input logic signed [15:0] ew,
                               input bit el, input bit eu);
      vec_t r;
      r.px = px; r.last = last; r.user = user; r.out = out;
      r.exp_relu = er; r.exp_raw = ew; r.exp_last = el; r.exp_user = eu;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Downstream ready pattern, updated just after each rising edge.
   initial begin
      int cyc;
      cyc = 0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Output monitor: scoreboard compare on handshake, stall stability.
   logic        stall_prev = 1'b0;
   logic [31:0] stall_data;
   logic [1:0]  stall_flags;
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev && m_relu.tvalid) begin
            chk("stall_hold_data", m_relu.tdata, stall_data);
            chk("stall_hold_flags", {30'b0, m_relu.tlast, m_relu.tuser},
                {30'b0, stall_flags});
         end
         if (m_relu.tvalid && !out_ready) begin
            chk("stall_in_ready_low", {31'b0, s_relu.tready}, 32'd0);
            stall_prev  = 1'b1;
            stall_data  = m_relu.tdata;
            stall_flags = {m_relu.tlast, m_relu.tuser};
         end else begin
            stall_prev = 1'b0;
         end
         if (m_relu.tvalid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output actual=%h expected=none",
                        m_relu.tdata);
            end else begin
               e = sb.pop_front();
               chk("out_tdata_relu", m_relu.tdata, {16'h0, e.relu});
               chk("out_tlast", {31'b0, m_relu.tlast}, {31'b0, e.last});
               chk("out_tuser", {31'b0, m_relu.tuser}, {31'b0, e.user});
               chk("out_tvalid_raw", {31'b0, m_raw.tvalid}, 32'd1);
               chk("out_tdata_raw", m_raw.tdata, {16'h0, e.raw});
               chk("out_tlast_raw", {31'b0, m_raw.tlast}, {31'b0, e.last});
            end
         end
      end
   end

   // Drive one beat (called just after a rising edge), push any expected
   // output, and return just after the edge on which the beat was accepted.
   task automatic send(input vec_t v, input bit push);
      exp_t e;
      int   n;
      in_valid = 1'b1;
      in_data  = {16'hA5A5, v.px};
      in_last  = v.last;
      in_user  = v.user;
      if (push && v.out) begin
         e.relu = v.exp_relu; e.raw = v.exp_raw;
         e.last = v.exp_last; e.user = v.exp_user;
         sb.push_back(e);
      end
      n = 0;
      @(negedge clk);
      while (!s_relu.tready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL input_accept_timeout actual=stalled expected=accept");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_user  = 1'b0;
   endtask

   task automatic run_a(input int n, input bit with_user, input bit push);
      vec_t v;
      for (int i = 0; i < n; i++) begin
         v = frame_a[i];
         if (i == 0 && !with_user) v.user = 1'b0;
         send(v, push);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || m_relu.tvalid) && n < 500) begin
         n++;
         @(posedge clk);
         #1;
      end
      chk("drain_done", {31'b0, (sb.size() == 0 && !m_relu.tvalid)}, 32'd1);
   endtask

   task automatic check_reset_state();
      chk("rst_m_tvalid", {31'b0, m_relu.tvalid}, 32'd0);
      chk("rst_m_tdata", m_relu.tdata, 32'd0);
      chk("rst_m_flags", {30'b0, m_relu.tlast, m_relu.tuser}, 32'd0);
      chk("rst_overflow", {30'b0, ovf_relu, ovf_raw}, 32'd0);
      chk("rst_s_tready", {31'b0, s_relu.tready}, 32'd1);
   endtask

   initial begin
      vec_t ov;
      // 4x4 frame: outputs relu 5,7,0,10 / raw 5,7,-2,10
      frame_a[0]  = mk(16'sd1,  0, 1, 0, 0, 0, 0, 0);
      frame_a[1]  = mk(16'sd5,  0, 0, 0, 0, 0, 0, 0);
      frame_a[2]  = mk(16'sd2,  0, 0, 0, 0, 0, 0, 0);
      frame_a[3]  = mk(16'sd3,  1, 0, 0, 0, 0, 0, 0);
      frame_a[4]  = mk(16'sd4,  0, 0, 0, 0, 0, 0, 0);
      frame_a[5]  = mk(16'sd0,  0, 0, 0, 0, 0, 0, 0);
      frame_a[6]  = mk(16'sd7,  0, 0, 1, 16'sd5, 16'sd5, 0, 1);
      frame_a[7]  = mk(-16'sd1, 1, 0, 1, 16'sd7, 16'sd7, 1, 0);
      frame_a[8]  = mk(-16'sd3, 0, 0, 0, 0, 0, 0, 0);
      frame_a[9]  = mk(-16'sd8, 0, 0, 0, 0, 0, 0, 0);
      frame_a[10] = mk(16'sd9,  0, 0, 0, 0, 0, 0, 0);
      frame_a[11] = mk(16'sd9,  1, 0, 0, 0, 0, 0, 0);
      frame_a[12] = mk(-16'sd2, 0, 0, 0, 0, 0, 0, 0);
      frame_a[13] = mk(-16'sd4, 0, 0, 0, 0, 0, 0, 0);
      frame_a[14] = mk(16'sd10, 0, 0, 1, 16'sd0, -16'sd2, 0, 0);
      frame_a[15] = mk(16'sd0,  1, 0, 1, 16'sd10, 16'sd10, 1, 0);
      // 5x2 frame: trailing pixel 9 dropped, outputs 2, 4(tlast)
      frame_b[0]  = mk(16'sd1, 0, 1, 0, 0, 0, 0, 0);
      frame_b[1]  = mk(16'sd2, 0, 0, 0, 0, 0, 0, 0);
      frame_b[2]  = mk(16'sd3, 0, 0, 0, 0, 0, 0, 0);
      frame_b[3]  = mk(16'sd4, 0, 0, 0, 0, 0, 0, 0);
      frame_b[4]  = mk(16'sd9, 1, 0, 0, 0, 0, 0, 0);
      frame_b[5]  = mk(16'sd0, 0, 0, 0, 0, 0, 0, 0);
      frame_b[6]  = mk(16'sd0, 0, 0, 0, 0, 0, 0, 0);
      frame_b[7]  = mk(16'sd0, 0, 0, 1, 16'sd2, 16'sd2, 0, 1);
      frame_b[8]  = mk(16'sd0, 0, 0, 0, 0, 0, 0, 0);
      frame_b[9]  = mk(16'sd0, 1, 0, 1, 16'sd4, 16'sd4, 1, 0);

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check_reset_state();
      chk("tstrb_all_ones", {28'b0, m_relu.tstrb}, 32'h0000000F);

      // basic frame, downstream always ready
      run_a(16, 1'b1, 1'b1);
      drain();

      // same frame with downstream ready toggling 1,0,0,1
      ready_mode = 1;
      run_a(16, 1'b1, 1'b1);
      drain();
      ready_mode = 0;

      // odd line width
      for (int i = 0; i < 10; i++) send(frame_b[i], 1'b1);
      drain();

      // frame restarted by tuser part-way through its first row
      run_a(3, 1'b1, 1'b0);
      run_a(16, 1'b1, 1'b1);
      drain();

      // reset while an output is stalled in the output register
      ready_mode = 2;
      repeat (2) @(posedge clk);
      #1;
      run_a(7, 1'b1, 1'b0);
      chk("pre_reset_tvalid", {31'b0, m_relu.tvalid}, 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_clears_tvalid", {30'b0, m_relu.tvalid, m_raw.tvalid}, 32'd0);
      reset = 1'b0;
      ready_mode = 0;
      // next frame starts without tuser; first output still flagged
      run_a(16, 1'b0, 1'b1);
      drain();

      // line longer than MAX_LINE_WIDTH
      for (int i = 0; i < 1026; i++) begin
         ov = mk(16'(i), (i == 1025), (i == 0), 0, 0, 0, 0, 0);
         send(ov, 1'b0);
      end
      @(posedge clk);
      #1;
      chk("overflow_set", {30'b0, ovf_relu, ovf_raw}, 32'd3);
      run_a(16, 1'b1, 1'b1);
      drain();
      chk("overflow_sticky", {30'b0, ovf_relu, ovf_raw}, 32'd3);

      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check_reset_state();

      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
